fetch_unit: RTL and testbench

- Instruction-fetch initiator for the P6 pipelined MIPS32 core.
- Owns the PC and drives the word-addressed, combinational-read instruction memory (base 0x3000, 4096 words); it is the requester side of the imem address/instr interface.
- Captures the returned word into the IF/ID pipeline register with valid/fault tags.
- Supports stall, flush, branch/jump redirect (delay-slot semantics) and a fetch-fault hold state.

---
 rtl/cpu_defs.sv | 25 ++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared constants, state encodings and address checks for the fetch stage
package cpu_defs;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;

    // 33-bit upper bound so the range check can never wrap past 2^32
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS * 4);

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HOLD = 1'b1
    } fetch_state_t;

    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00)
            || ({1'b0, addr} < {1'b0, IM_BASE})
            || ({1'b0, addr} >= IM_LIMIT);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with reset > flush > stall > load priority
import cpu_defs::*;

module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        bubble,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic        d_fault,
    output logic [31:0] q_instr,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc8,
    output logic        q_valid,
    output logic        q_fault
);

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && bubble)) begin
            q_instr <= NOP;
            q_pc    <= 32'h0;
            q_pc8   <= 32'h0;
            q_valid <= 1'b0;
            q_fault <= 1'b0;
        end else if (!stall) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc8   <= d_pc + 32'd8;
            q_valid <= 1'b1;
            q_fault <= d_fault;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem requester and fetch-fault hold FSM feeding IF/ID
import cpu_defs::*;

module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        if_id_fault
);

    logic [31:0]  pc;
    fetch_state_t state;
    logic         fault;

    assign imem_addr = pc;
    assign fault     = addr_fault(pc);

    // A faulting fetch parks the PC in HOLD until a redirect (exception entry) arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= PC_RESET;
            state <= FS_RUN;
        end else if (!stall) begin
            case (state)
                FS_RUN: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (fault) begin
                        state <= FS_HOLD;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= FS_RUN;
                    end
                end
                default: state <= FS_RUN;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .stall   (stall),
        .bubble  (state == FS_HOLD),
        .d_instr (fault ? NOP : imem_instr),
        .d_pc    (pc),
        .d_fault (fault),
        .q_instr (if_id_instr),
        .q_pc    (if_id_pc),
        .q_pc8   (if_id_pc8),
        .q_valid (if_id_valid),
        .q_fault (if_id_fault)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
    logic        if_id_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc8      (if_id_pc8),
        .if_id_valid    (if_id_valid),
        .if_id_fault    (if_id_fault)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_ipc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                       input logic [31:0] ea, input logic [31:0] eipc, input logic ev, input logic ef);
        vec_t v;
        v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
        v.e_addr = ea; v.e_ipc = eipc; v.e_valid = ev; v.e_fault = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected IF/ID contents derived from the latched PC and its tags
    task automatic chk_state(input string tag, input logic [31:0] ea, input logic [31:0] eipc,
                             input logic ev, input logic ef);
        logic [31:0] x_instr, x_pc, x_pc8;
        x_pc    = ev ? eipc : 32'h0;
        x_pc8   = ev ? eipc + 32'd8 : 32'h0;
        x_instr = (ev && !ef) ? mem_word(eipc) : 32'h0;
        chk({tag, ".imem_addr"},   imem_addr,   ea);
        chk({tag, ".if_id_instr"}, if_id_instr, x_instr);
        chk({tag, ".if_id_pc"},    if_id_pc,    x_pc);
        chk({tag, ".if_id_pc8"},   if_id_pc8,   x_pc8);
        chk({tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, ev});
        chk({tag, ".if_id_fault"}, {31'h0, if_id_fault}, {31'h0, ef});
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] rpc);
        reset = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //   stall flush rv  rpc            addr           if_id_pc       v     f
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0000_3100, 32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0000_3100, 32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'h0000_3100, 32'h0000_3008, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3104, 32'h0000_3100, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_3104, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_4180, 32'h0000_4180, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_4184, 32'h0000_4180, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3102, 32'h0000_3102, 32'h0000_4184, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3102, 32'h0000_3102, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3102, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3102, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_4180, 32'h0000_4180, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_4184, 32'h0000_4180, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 32'h0000_6FFC, 32'h0000_4184, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_7000, 32'h0000_6FFC, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_7000, 32'h0000_7000, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2FFC, 32'h0000_2FFC, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, 32'h0,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_7000, 32'h0000_3000, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3200, 32'h0000_3200, 32'h0000_7000, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3204, 32'h0000_3200, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_3208, 32'h0,         1'b0, 1'b0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_state("reset", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].stall, vecs[i].flush, vecs[i].rv, vecs[i].rpc);
            chk_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ipc,
                      vecs[i].e_valid, vecs[i].e_fault);
        end

        // imem_addr must not react combinationally to redirect/stall inputs
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5000; stall = 1'b1;
        #1;
        chk("comb_path.imem_addr", imem_addr, 32'h0000_3208);

        // Enter HOLD via a misaligned target, then reset while stalled
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3102);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_state("hold_entry", 32'h0000_3102, 32'h0000_3102, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_state("reset_in_hold", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_state("run_after_reset", 32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
